mac_operand_loader: RTL

Front-end sequencer for the complex multiply-accumulate unit. It collects eight packed complex operand bytes from a valid/ready byte stream into x0..x3 / y0..y3. It then pulses `mac_start` and holds the operands stable until the MAC signals completion. It captures the 20-bit `{real, imag}` result and offers it on a valid/ready result port, so the MAC can be driven from a plain stream instead of parallel buses.

---
 rtl/mac_operand_loader_pkg.sv | 32 +++
 rtl/mac_operand_loader_if.sv | 48 ++++
 rtl/mac_operand_loader_operand_bank.sv | 34 +++
 rtl/mac_operand_loader.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mac_operand_loader_pkg.sv
// ---------------------------------------------------------------------------
// mac_operand_loader_pkg
//
// Shared definitions for the MAC operand loader slice.
//   OPND_W   : width of one packed complex operand byte {re[3:0], im[3:0]}
//   RES_W    : width of the MAC result {real[9:0], imag[9:0]}
//   NUM_OPND : operand bytes per frame (x0,y0,x1,y1,x2,y2,x3,y3)
//   IDX_W    : width of the byte index inside a frame
//   TMO_W    : width of the WAIT-phase timeout counter
//   state_t  : loader FSM states ST_FILL, ST_START, ST_WAIT, ST_OUT
//   is_rising: single-cycle rising-edge detect on a level and its registered copy
// ---------------------------------------------------------------------------
package mac_operand_loader_pkg;

    localparam int OPND_W   = 8;
    localparam int RES_W    = 20;
    localparam int NUM_OPND = 8;
    localparam int IDX_W    = 3;
    localparam int TMO_W    = 8;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    function automatic logic is_rising(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/mac_operand_loader_if.sv
// ---------------------------------------------------------------------------
// mac_operand_loader_if
//
// Stream-side bundle of the operand loader: the byte input stream and the
// result output stream, both valid/ready.
//   in_data   : operand byte {re[3:0], im[3:0]}
//   in_valid  : in_data is valid
//   in_ready  : loader accepts a byte this cycle
//   res_data  : captured MAC result {real[9:0], imag[9:0]}
//   res_err   : result came from a timeout (res_data is then 0)
//   res_valid : result is available
//   res_ready : consumer takes the result
// Modports:
//   slave  - the loader's view (consumes bytes, produces results)
//   master - the producer/consumer side driving the loader
// ---------------------------------------------------------------------------
interface mac_operand_loader_if;
    import mac_operand_loader_pkg::*;

    logic [OPND_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [RES_W-1:0]  res_data;
    logic              res_err;
    logic              res_valid;
    logic              res_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        input  res_ready,
        output in_ready,
        output res_data,
        output res_err,
        output res_valid
    );

    modport master (
        output in_data,
        output in_valid,
        output res_ready,
        input  in_ready,
        input  res_data,
        input  res_err,
        input  res_valid
    );

endinterface

// File: rtl/mac_operand_loader_operand_bank.sv
// ---------------------------------------------------------------------------
// operand_bank
//
// Eight operand byte registers loaded one at a time by index. Entry k holds
// frame byte k, so even entries are the x operands and odd entries the y
// operands. Contents only change on a write, which keeps the operands stable
// while the MAC is working.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low clear of all entries
//   we   : write enable
//   idx  : entry written when we=1
//   data : byte written
//   regs : all eight entries, entry k at regs[k]
// ---------------------------------------------------------------------------
module operand_bank
    import mac_operand_loader_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we,
    input  logic [IDX_W-1:0]                    idx,
    input  logic [OPND_W-1:0]                   data,
    output logic [NUM_OPND-1:0][OPND_W-1:0]     regs
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else if (we) begin
            regs[idx] <= data;
        end
    end

endmodule

// File: rtl/mac_operand_loader.sv
// ---------------------------------------------------------------------------
// mac_operand_loader
//
// Front-end sequencer for the complex MAC. Collects eight operand bytes from
// a valid/ready byte stream, pulses mac_start, waits for a rising edge on
// mac_done (or gives up after TIMEOUT wait cycles) and offers the captured
// result on a valid/ready result stream.
//   TIMEOUT   : max WAIT cycles for a mac_done rising edge (4..255)
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   bus       : byte input stream and result output stream (slave modport)
//   x0..x3    : x operands to the MAC (frame bytes 0,2,4,6)
//   y0..y3    : y operands to the MAC (frame bytes 1,3,5,7)
//   mac_start : one-cycle start pulse to the MAC
//   mac_done  : MAC completion level
//   mac_out   : MAC result {real[9:0], imag[9:0]}
// ---------------------------------------------------------------------------
module mac_operand_loader
    import mac_operand_loader_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic                 clk,
    input  logic                 rst,
    mac_operand_loader_if.slave  bus,
    output logic [OPND_W-1:0]    x0,
    output logic [OPND_W-1:0]    x1,
    output logic [OPND_W-1:0]    x2,
    output logic [OPND_W-1:0]    x3,
    output logic [OPND_W-1:0]    y0,
    output logic [OPND_W-1:0]    y1,
    output logic [OPND_W-1:0]    y2,
    output logic [OPND_W-1:0]    y3,
    output logic                 mac_start,
    input  logic                 mac_done,
    input  logic [RES_W-1:0]     mac_out
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPND - 1);

    state_t                            state;
    logic [IDX_W-1:0]                  idx;
    logic [TMO_W-1:0]                  tmo;
    logic                              mac_done_q;
    logic                              in_ready_q;
    logic                              res_valid_q;
    logic                              res_err_q;
    logic [RES_W-1:0]                  res_data_q;
    logic                              accept;
    logic                              done_edge;
    logic [NUM_OPND-1:0][OPND_W-1:0]   opnd;

    // in_ready is only ever high in FILL, so the handshake alone is enough
    // to qualify a byte write.
    assign accept    = bus.in_valid & in_ready_q;
    assign done_edge = is_rising(mac_done, mac_done_q);

    operand_bank u_bank (
        .clk  (clk),
        .rst  (rst),
        .we   (accept),
        .idx  (idx),
        .data (bus.in_data),
        .regs (opnd)
    );

    assign x0 = opnd[0];
    assign y0 = opnd[1];
    assign x1 = opnd[2];
    assign y1 = opnd[3];
    assign x2 = opnd[4];
    assign y2 = opnd[5];
    assign x3 = opnd[6];
    assign y3 = opnd[7];

    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_err   = res_err_q;
    assign bus.res_data  = res_data_q;

    // Loader FSM. in_ready, res_valid and mac_start are registered copies of
    // the state being entered, so each one lines up with its state register
    // value without any combinational decode on the outputs. in_ready stays
    // low for the first cycle after reset because it only rises on the first
    // clock edge spent in FILL.
    // mac_done_q follows mac_done every cycle, including START, so a done
    // level that is already high when the frame starts never looks like an
    // edge in WAIT.
    // In WAIT the edge check comes before the timeout check so an edge that
    // lands on the last allowed cycle still produces a clean result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_FILL;
            idx         <= '0;
            tmo         <= '0;
            mac_done_q  <= 1'b0;
            mac_start   <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
        end else begin
            mac_done_q <= mac_done;
            mac_start  <= 1'b0;
            case (state)
                ST_FILL: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        if (idx == IDX_LAST) begin
                            idx        <= '0;
                            in_ready_q <= 1'b0;
                            mac_start  <= 1'b1;
                            state      <= ST_START;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_START: begin
                    tmo   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_edge) begin
                        res_data_q  <= mac_out;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state       <= ST_OUT;
                    end else if (tmo == TMO_LAST) begin
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state       <= ST_OUT;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                ST_OUT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_FILL;
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule
